// File: rtl/apu_tri_regs.sv
// Triangle-channel register front end: decodes CPU writes to the four
// triangle registers and runs the length and linear counters that gate the generator.
module apu_tri_regs #(
  parameter logic [15:0] BASE_ADDR = 16'h4008
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        chan_en,
  input  logic        qframe_tick,
  input  logic        hframe_tick,
  output logic [7:0]  r4008,
  output logic [7:0]  r4009,
  output logic [7:0]  r400a,
  output logic [7:0]  r400b,
  output logic [7:0]  len_cnt,
  output logic [6:0]  lin_cnt,
  output logic        len_active,
  output logic        gate
);

  // Write port handshake: cpu_we acts as a valid with an implicit, always-high
  // ready. Every cycle with cpu_we = 1 is exactly one accepted write.

  logic [7:0]  r4008_q, r4008_d;
  logic [7:0]  r4009_q, r4009_d;
  logic [7:0]  r400a_q, r400a_d;
  logic [7:0]  r400b_q, r400b_d;
  logic [7:0]  len_cnt_q, len_cnt_d;
  logic [6:0]  lin_cnt_q, lin_cnt_d;
  logic        reload_q, reload_d;

  logic [15:0] offset;
  logic        hit;
  logic        wr_4008, wr_4009, wr_400a, wr_400b;

  function automatic logic [7:0] len_lookup(input logic [4:0] idx);
    logic [7:0] v;
    case (idx)
      5'd0:  v = 8'd10;   5'd1:  v = 8'd254;  5'd2:  v = 8'd20;   5'd3:  v = 8'd2;
      5'd4:  v = 8'd40;   5'd5:  v = 8'd4;    5'd6:  v = 8'd80;   5'd7:  v = 8'd6;
      5'd8:  v = 8'd160;  5'd9:  v = 8'd8;    5'd10: v = 8'd60;   5'd11: v = 8'd10;
      5'd12: v = 8'd14;   5'd13: v = 8'd12;   5'd14: v = 8'd26;   5'd15: v = 8'd14;
      5'd16: v = 8'd12;   5'd17: v = 8'd16;   5'd18: v = 8'd24;   5'd19: v = 8'd18;
      5'd20: v = 8'd48;   5'd21: v = 8'd20;   5'd22: v = 8'd96;   5'd23: v = 8'd22;
      5'd24: v = 8'd192;  5'd25: v = 8'd24;   5'd26: v = 8'd72;   5'd27: v = 8'd26;
      5'd28: v = 8'd16;   5'd29: v = 8'd28;   5'd30: v = 8'd32;   default: v = 8'd30;
    endcase
    return v;
  endfunction

  // Modular subtraction: addresses below BASE_ADDR wrap to large offsets and miss.
  assign offset  = cpu_addr - BASE_ADDR;
  assign hit     = cpu_we && (offset[15:2] == 14'd0);
  assign wr_4008 = hit && (offset[1:0] == 2'd0);
  assign wr_4009 = hit && (offset[1:0] == 2'd1);
  assign wr_400a = hit && (offset[1:0] == 2'd2);
  assign wr_400b = hit && (offset[1:0] == 2'd3);

  always_comb begin
    r4008_d = r4008_q;
    r4009_d = r4009_q;
    r400a_d = r400a_q;
    r400b_d = r400b_q;
    if (wr_4008) r4008_d = cpu_wdata;
    if (wr_4009) r4009_d = cpu_wdata;
    if (wr_400a) r400a_d = cpu_wdata;
    if (wr_400b) r400b_d = cpu_wdata;
  end

  // Ticks read only _q values, so a same-cycle write never affects the tick.
  always_comb begin
    len_cnt_d = len_cnt_q;
    if (hframe_tick && (len_cnt_q != 8'd0) && !r4008_q[7])
      len_cnt_d = len_cnt_q - 8'd1;
    if (wr_400b && chan_en)
      len_cnt_d = len_lookup(cpu_wdata[7:3]);
    if (!chan_en)
      len_cnt_d = 8'd0;
  end

  always_comb begin
    lin_cnt_d = lin_cnt_q;
    reload_d  = reload_q;
    if (qframe_tick) begin
      if (reload_q)
        lin_cnt_d = r4008_q[6:0];
      else if (lin_cnt_q != 7'd0)
        lin_cnt_d = lin_cnt_q - 7'd1;
      if (!r4008_q[7])
        reload_d = 1'b0;
    end
    if (wr_400b)
      reload_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r4008_q   <= 8'd0;
      r4009_q   <= 8'd0;
      r400a_q   <= 8'd0;
      r400b_q   <= 8'd0;
      len_cnt_q <= 8'd0;
      lin_cnt_q <= 7'd0;
      reload_q  <= 1'b0;
    end else begin
      r4008_q   <= r4008_d;
      r4009_q   <= r4009_d;
      r400a_q   <= r400a_d;
      r400b_q   <= r400b_d;
      len_cnt_q <= len_cnt_d;
      lin_cnt_q <= lin_cnt_d;
      reload_q  <= reload_d;
    end
  end

  assign r4008      = r4008_q;
  assign r4009      = r4009_q;
  assign r400a      = r400a_q;
  assign r400b      = r400b_q;
  assign len_cnt    = len_cnt_q;
  assign lin_cnt    = lin_cnt_q;
  assign len_active = (len_cnt_q != 8'd0);
  assign gate       = (len_cnt_q != 8'd0) && (lin_cnt_q != 7'd0);

endmodule

// File: tb/tb_apu_tri_regs.sv
// Directed bench for apu_tri_regs: expected output snapshots are queued as each
// step is driven and popped for comparison once the clock edge has landed.
module tb_apu_tri_regs;

  localparam int W = 49;

  logic        clk;
  logic        rst_n;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        chan_en;
  logic        qframe_tick;
  logic        hframe_tick;
  logic [7:0]  r4008, r4009, r400a, r400b, len_cnt;
  logic [6:0]  lin_cnt;
  logic        len_active, gate;

  logic [W-1:0] exp_q[$];
  int           checks;
  int           passed;

  // Expected register/counter values, set by the sequence before each step.
  logic [7:0]   e08, e09, e0a, e0b, elen;
  logic [6:0]   elin;

  apu_tri_regs #(.BASE_ADDR(16'h4008)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cpu_we      (cpu_we),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .chan_en     (chan_en),
    .qframe_tick (qframe_tick),
    .hframe_tick (hframe_tick),
    .r4008       (r4008),
    .r4009       (r4009),
    .r400a       (r400a),
    .r400b       (r400b),
    .len_cnt     (len_cnt),
    .lin_cnt     (lin_cnt),
    .len_active  (len_active),
    .gate        (gate)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] exp_vec();
    return {e08, e09, e0a, e0b, elen, elin, (elen != 8'd0),
            ((elen != 8'd0) && (elin != 7'd0))};
  endfunction

  task automatic check(input string tag);
    logic [W-1:0] obs;
    logic [W-1:0] expv;
    obs = {r4008, r4009, r400a, r400b, len_cnt, lin_cnt, len_active, gate};
    checks++;
    if (exp_q.size() == 0) begin
      $error("FAIL %s: scoreboard empty, observed %h", tag, obs);
    end else begin
      expv = exp_q.pop_front();
      assert (obs === expv) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Driver: one clock with the given write/tick inputs, then compare.
  task automatic step(input logic we, input logic [15:0] addr, input logic [7:0] data,
                      input logic q, input logic h, input string tag);
    @(negedge clk);
    cpu_we      = we;
    cpu_addr    = addr;
    cpu_wdata   = data;
    qframe_tick = q;
    hframe_tick = h;
    exp_q.push_back(exp_vec());
    @(posedge clk);
    #1;
    cpu_we      = 1'b0;
    qframe_tick = 1'b0;
    hframe_tick = 1'b0;
    check(tag);
  endtask

  task automatic set_exp_zero();
    e08 = 8'h00; e09 = 8'h00; e0a = 8'h00; e0b = 8'h00; elen = 8'd0; elin = 7'd0;
  endtask

  initial begin
    checks = 0;
    passed = 0;
    rst_n = 1'b0;
    cpu_we = 1'b0; cpu_addr = 16'h0; cpu_wdata = 8'h0;
    chan_en = 1'b0; qframe_tick = 1'b0; hframe_tick = 1'b0;
    set_exp_zero();

    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back(exp_vec());
    check("reset_state");
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 16'h0, 8'h0, 1'b0, 1'b0, "idle");

    // Length counter load and decrement
    chan_en = 1'b1;
    e0b = 8'h08; elen = 8'd254;
    step(1'b1, 16'h400B, 8'h08, 1'b0, 1'b0, "len_load");
    for (int i = 1; i <= 3; i++) begin
      elen = 8'(254 - i);
      step(1'b0, 16'h0, 8'h0, 1'b0, 1'b1, "len_dec");
    end
    chan_en = 1'b0;
    elen = 8'd0;
    step(1'b0, 16'h0, 8'h0, 1'b0, 1'b0, "chan_off");
    e0b = 8'h10;
    step(1'b1, 16'h400B, 8'h10, 1'b0, 1'b0, "load_blocked");
    chan_en = 1'b1;
    step(1'b0, 16'h0, 8'h0, 1'b0, 1'b1, "len_no_wrap");

    // Linear counter
    e08 = 8'h05;
    step(1'b1, 16'h4008, 8'h05, 1'b0, 1'b0, "wr_4008");
    e0b = 8'h08; elen = 8'd254;
    step(1'b1, 16'h400B, 8'h08, 1'b0, 1'b0, "len_reload");
    elin = 7'd5;
    step(1'b0, 16'h0, 8'h0, 1'b1, 1'b0, "lin_reload");
    for (int i = 4; i >= 0; i--) begin
      elin = 7'(i);
      step(1'b0, 16'h0, 8'h0, 1'b1, 1'b0, "lin_dec");
    end
    step(1'b0, 16'h0, 8'h0, 1'b1, 1'b0, "lin_floor");

    // Halt / control
    e08 = 8'h83;
    step(1'b1, 16'h4008, 8'h83, 1'b0, 1'b0, "wr_halt");
    e0b = 8'h00; elen = 8'd10;
    step(1'b1, 16'h400B, 8'h00, 1'b0, 1'b0, "halt_load");
    repeat (4) step(1'b0, 16'h0, 8'h0, 1'b0, 1'b1, "halt_freeze");
    elin = 7'd3;
    step(1'b0, 16'h0, 8'h0, 1'b1, 1'b0, "halt_lin_reload");
    step(1'b0, 16'h0, 8'h0, 1'b1, 1'b0, "halt_lin_reload2");
    e08 = 8'h02;
    step(1'b1, 16'h4008, 8'h02, 1'b0, 1'b0, "wr_unhalt");
    elin = 7'd2;
    step(1'b0, 16'h0, 8'h0, 1'b1, 1'b0, "flag_persisted");
    elin = 7'd1;
    step(1'b0, 16'h0, 8'h0, 1'b1, 1'b0, "flag_cleared");

    // Collision: $400B write with hframe_tick
    elen = 8'd10;
    step(1'b1, 16'h400B, 8'h00, 1'b0, 1'b0, "coll_setup_load");
    for (int i = 9; i >= 7; i--) begin
      elen = 8'(i);
      step(1'b0, 16'h0, 8'h0, 1'b0, 1'b1, "coll_setup_dec");
    end
    e0b = 8'h18; elen = 8'd2;
    step(1'b1, 16'h400B, 8'h18, 1'b0, 1'b1, "coll_len");

    // Collision: $400B write with qframe_tick, flag clear
    e08 = 8'h05;
    step(1'b1, 16'h4008, 8'h05, 1'b0, 1'b0, "coll_wr_4008");
    elin = 7'd5;
    step(1'b0, 16'h0, 8'h0, 1'b1, 1'b0, "coll_clear_flag");
    elin = 7'd4;
    step(1'b0, 16'h0, 8'h0, 1'b1, 1'b0, "coll_lin4");
    elin = 7'd3;
    step(1'b1, 16'h400B, 8'h18, 1'b1, 1'b0, "coll_lin");
    elin = 7'd5;
    step(1'b0, 16'h0, 8'h0, 1'b1, 1'b0, "coll_flag_set");

    // Both ticks together
    elin = 7'd4; elen = 8'd1;
    step(1'b0, 16'h0, 8'h0, 1'b1, 1'b1, "q_and_h");

    // Address decode
    step(1'b1, 16'h4007, 8'hFF, 1'b0, 1'b0, "decode_below");
    step(1'b1, 16'h400C, 8'hFF, 1'b0, 1'b0, "decode_above");
    step(1'b0, 16'h4008, 8'hFF, 1'b0, 1'b0, "decode_no_we");
    e09 = 8'hAA;
    step(1'b1, 16'h4009, 8'hAA, 1'b0, 1'b0, "wr_4009");
    e0a = 8'h5C;
    step(1'b1, 16'h400A, 8'h5C, 1'b0, 1'b0, "wr_400a");

    // Asynchronous reset mid-cycle
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    set_exp_zero();
    exp_q.push_back(exp_vec());
    check("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 16'h0, 8'h0, 1'b1, 1'b1, "post_reset_idle");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
